// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display path.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package alu_disp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [6:0] SEG_MINUS  = 7'h3F;
   localparam int         BCD_DIGITS = 7;

   // Entry n holds the pattern for decimal digit n.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/alu_result_display_bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Codes outside 0..9 and the blank request both produce an unlit digit.
module bcd_to_seg7
   import alu_disp_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      if (blank || (digit > 4'd9)) begin
         seg = SEG_BLANK;
      end else begin
         seg = SEG_TABLE[digit];
      end
   end

endmodule

// File: rtl/alu_result_display.sv
// Accepts an ALU result, converts it to BCD by serial double-dabble and drives six
// blanked seven-segment digits. Define SIGNED_RESULT_EN to honour in_signed.
module alu_result_display
   import alu_disp_pkg::*;
#(
   parameter int DATA_W     = 20,
   parameter int NUM_DIGITS = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_result,
   input  logic                    in_signed,
   output logic [7*NUM_DIGITS-1:0] hex_o,
   output logic                    ovf,
   output logic                    done
);

   localparam int BCD_W = 4 * BCD_DIGITS;
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   state_t                  state;
   logic [DATA_W-1:0]       shift_q;
   logic [BCD_W-1:0]        bcd_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    neg_q;
   logic [7*NUM_DIGITS-1:0] hex_q;
   logic                    ovf_q;
   logic                    done_q;

   logic                    neg_in;
   logic [DATA_W-1:0]       mag_in;
   logic [BCD_W-1:0]        bcd_adj;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    seen;
   logic [7*NUM_DIGITS-1:0] seg_w;
   logic [7*NUM_DIGITS-1:0] disp_seg;
   logic                    disp_ovf;

`ifdef SIGNED_RESULT_EN
   always_comb begin
      neg_in = in_signed && in_result[DATA_W-1];
      mag_in = neg_in ? (~in_result + DATA_W'(1)) : in_result;
   end
`else
   logic unused_signed;
   assign unused_signed = in_signed;

   always_comb begin
      neg_in = 1'b0;
      mag_in = in_result;
   end
`endif

   // NOTE: every combinational output gets a value before any branch, so no latch can form.
   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                        : bcd_q[4*i +: 4];
      end
   end

   // Scan from the top digit down; a digit stays blank until a nonzero digit is seen.
   always_comb begin
      seen  = 1'b0;
      blank = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         seen     = seen | (bcd_q[4*i +: 4] != 4'd0);
         blank[i] = !seen;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_to_seg7 u_seg (
         .digit (bcd_q[4*g +: 4]),
         .blank (blank[g]),
         .seg   (seg_w[7*g +: 7])
      );
   end

   // A negative value loses its top digit to the minus sign, so its limit is one digit shorter.
   always_comb begin
      disp_ovf = neg_q ? (|bcd_q[BCD_W-1:4*(NUM_DIGITS-1)])
                       : (|bcd_q[BCD_W-1:4*NUM_DIGITS]);
      disp_seg = seg_w;
      if (disp_ovf) begin
         disp_seg = {NUM_DIGITS{SEG_MINUS}};
      end else if (neg_q) begin
         disp_seg[7*NUM_DIGITS-1 -: 7] = SEG_MINUS;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         hex_q   <= {NUM_DIGITS{SEG_BLANK}};
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  shift_q <= mag_in;
                  neg_q   <= neg_in;
                  bcd_q   <= '0;
                  cnt_q   <= '0;
                  state   <= CONV;
               end
            end
            CONV: begin
               {bcd_q, shift_q} <= {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
               cnt_q            <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_STEP) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               hex_q  <= disp_seg;
               ovf_q  <= disp_ovf;
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready = (state == IDLE);
   assign hex_o    = hex_q;
   assign ovf      = ovf_q;
   assign done     = done_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Self-checking bench for alu_result_display against a decimal-arithmetic reference model.
// Compile with the same SIGNED_RESULT_EN setting as the RTL.
module tb_alu_result_display;

   localparam int DATA_W     = 20;
   localparam int NUM_DIGITS = 6;
   localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] in_result;
   logic        in_signed;
   logic [41:0] hex_o;
   logic        ovf;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   alu_result_display #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_result (in_result),
      .in_signed (in_signed),
      .hex_o     (hex_o),
      .ovf       (ovf),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Reference: decimal digits by division, blanking above the most significant nonzero digit.
   task automatic model(input logic [19:0] v, input logic s,
                        output logic [41:0] hex, output logic exp_ovf);
      bit          neg;
      int unsigned mag;
      int unsigned limit;
      int unsigned pw;
      int          d [6];
      int          msd;
      neg = 1'b0;
`ifdef SIGNED_RESULT_EN
      neg = s && v[19];
`endif
      mag   = neg ? ((32'd1 << 20) - 32'(v)) : 32'(v);
      limit = neg ? 99999 : 999999;
      if (mag > limit) begin
         hex     = {6{7'h3F}};
         exp_ovf = 1'b1;
      end else begin
         exp_ovf = 1'b0;
         msd     = 0;
         pw      = 1;
         for (int i = 0; i < 6; i++) begin
            d[i] = int'((mag / pw) % 10);
            if (d[i] != 0) msd = i;
            pw = pw * 10;
         end
         for (int i = 0; i < 6; i++) begin
            hex[i*7 +: 7] = (i <= msd) ? seg_tab[d[i]] : 7'h7F;
         end
         if (neg) hex[41:35] = 7'h3F;
      end
   endtask

   // Presents one value, waits for acceptance and returns edges from accept to done (-1 on timeout).
   task automatic run_txn(input logic [19:0] v, input logic s, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_result = v;
      in_signed = s;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_result = 20'($urandom);
      in_signed = 1'($urandom);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic check_result(input string name, input logic [19:0] v, input logic s);
      logic [41:0] eh;
      logic        eo;
      model(v, s, eh, eo);
      n_checks++;
      if (hex_o !== eh) begin
         n_fail++;
         $display("FAIL %s hex: value=%0d signed=%0b got=%h want=%h", name, v, s, hex_o, eh);
      end
      n_checks++;
      if (ovf !== eo) begin
         n_fail++;
         $display("FAIL %s ovf: value=%0d got=%0b want=%0b", name, v, ovf, eo);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_result = '0;
      in_signed = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (hex_o !== ALL_BLANK || in_ready !== 1'b1 || done !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: hex=%h ready=%b done=%b ovf=%b want hex=%h ready=1 done=0 ovf=0",
                  hex_o, in_ready, done, ovf, ALL_BLANK);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      int lat;
      logic [19:0] vals [10] = '{20'd30, 20'd491520, 20'hFFFFF, 20'd0, 20'd999999,
                                 20'd1000000, 20'(1048576 - 99999), 20'(1048576 - 100000),
                                 20'h80000, 20'd7};
      logic        sgns [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      run_txn(20'd30, 1'b0, lat);
      n_checks++;
      if (lat != 21) begin
         n_fail++;
         $display("FAIL latency: got=%0d edges want=21", lat);
      end
      n_checks++;
      if (hex_o !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40} || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL literal_30: got=%h ovf=%b", hex_o, ovf);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse: got=%b want=0 one cycle after done", done);
      end
      run_txn(20'd491520, 1'b0, lat);
      n_checks++;
      if (hex_o !== {7'h19, 7'h10, 7'h79, 7'h12, 7'h24, 7'h40} || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL literal_491520: got=%h ovf=%b", hex_o, ovf);
      end
      for (int i = 0; i < 10; i++) begin
         run_txn(vals[i], sgns[i], lat);
         n_checks++;
         if (lat != 21) begin
            n_fail++;
            $display("FAIL directed_latency: value=%0d got=%0d want=21", vals[i], lat);
         end
         check_result("directed", vals[i], sgns[i]);
      end
   endtask

   task automatic test_idle_inputs();
      logic [41:0] held_hex;
      logic        held_ovf;
      held_hex = hex_o;
      held_ovf = ovf;
      repeat (8) begin
         @(negedge clk);
         in_result = 20'($urandom);
         in_signed = 1'($urandom);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (hex_o !== held_hex || ovf !== held_ovf || done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_inputs: hex=%h ovf=%b done=%b want hex=%h ovf=%b done=0",
                  hex_o, ovf, done, held_hex, held_ovf);
      end
   endtask

   task automatic test_random();
      int lat;
      logic [19:0] v;
      logic        s;
      for (int n = 0; n < 40; n++) begin
         v = 20'($urandom) >> $urandom_range(0, 19);
         s = 1'($urandom);
         if (n % 4 == 0) v = 20'($urandom);
         run_txn(v, s, lat);
         n_checks++;
         if (lat != 21) begin
            n_fail++;
            $display("FAIL random_latency: value=%0d got=%0d want=21", v, lat);
         end
         check_result("random", v, s);
      end
   endtask

   task automatic test_back_to_back();
      int gap;
      int first;
      logic [19:0] a;
      logic [19:0] b;
      a = 20'd123456;
      b = 20'd4321;
      first = -1;
      gap   = -1;
      @(negedge clk);
      in_valid  = 1'b1;
      in_result = a;
      in_signed = 1'b0;
      @(posedge clk);
      #1;
      in_result = b;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (first < 0 && k < 21) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_ready: edge=%0d got=%b want=0", k, in_ready);
            end
         end
         if (done && first < 0) begin
            first = k;
            check_result("b2b_first", a, 1'b0);
         end else if (k == first + 1) begin
            in_valid = 1'b0;
         end else if (done && first >= 0) begin
            gap = k - first;
            break;
         end
      end
      n_checks++;
      if (first != 21 || gap != 22) begin
         n_fail++;
         $display("FAIL b2b_timing: first=%0d want=21 gap=%0d want=22", first, gap);
      end
      check_result("b2b_second", b, 1'b0);
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      int seen_done;
      seen_done = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_result = 20'd654321;
      in_signed = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || hex_o !== ALL_BLANK || done !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: ready=%b hex=%h done=%b ovf=%b", in_ready, hex_o, done, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done) seen_done++;
      end
      n_checks++;
      if (seen_done != 0 || hex_o !== ALL_BLANK) begin
         n_fail++;
         $display("FAIL reset_mid_discard: done_pulses=%0d want=0 hex=%h", seen_done, hex_o);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_idle_inputs();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
